sr_delay_sched: RTL and testbench

- Sequencing controller wrapped around a fixed-depth, tapped shift-register delay line.
- Presents the delay line as a valid/ready stream stage with runtime-programmable delay length L (1..depth).
- Tracks fill level, gates the common shift enable, selects the output tap, and drains contents on flush.
- Data stages carry no reset and share one enable, so synthesis can map them to SRL primitives.

---
 rtl/sr_delay_sched_if.sv | 22 ++
 rtl/sr_delay_sched.sv | 139 +++++++++++++
 tb/tb_sr_delay_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_delay_sched_if.sv
// Valid/ready stream bundle for the tapped delay line: upstream input side
// and downstream output side.
interface sr_delay_sched_if #(
  parameter int width = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sr_delay_sched.sv
// Sequencing controller around a fixed-depth tapped shift register, exposed
// as a valid/ready stage with a runtime-programmable delay length.
module sr_delay_sched #(
  parameter int width = 8,
  parameter int depth = 130,
  parameter int lenw  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [lenw-1:0] cfg_len,
  input  logic            cfg_load,
  output logic            cfg_err,
  input  logic            flush,
  output logic [lenw-1:0] fill,
  output logic            busy,
  sr_delay_sched_if.slave s
);

  typedef enum logic [1:0] {EMPTY, FILL, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [lenw-1:0]  fill_q, fill_d;
  logic [lenw-1:0]  len_q, len_d;
  logic             cfg_err_q, cfg_err_d;

  logic [width-1:0] sr_q [depth];
  logic [width-1:0] sr_d [depth];

  logic             in_ready_c, out_valid_c;
  logic             ih, oh;
  logic             cfg_ok;
  logic [lenw-1:0]  fill_inc;
  logic [lenw-1:0]  tap_idx;
  logic [width-1:0] tap;

  // RUN couples the two sides combinationally so a push and a pop coincide.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    if (!rst) begin
      case (state_q)
        EMPTY, FILL: in_ready_c = 1'b1;
        RUN: begin
          in_ready_c  = s.out_ready;
          out_valid_c = s.in_valid;
        end
        FLUSH:   out_valid_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign ih = s.in_valid && in_ready_c;
  assign oh = out_valid_c && s.out_ready;

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_c;

  assign tap_idx = fill_q - lenw'(1);

  always_comb begin
    tap = '0;
    for (int k = 0; k < depth; k++) begin
      if (tap_idx == lenw'(k)) tap = sr_q[k];
    end
  end

  assign s.out_data = out_valid_c ? tap : '0;

  always_comb begin
    sr_d[0] = s.in_data;
    for (int k = 1; k < depth; k++) sr_d[k] = sr_q[k-1];
  end

  // Data stages: no reset and a single shared enable so they map onto SRLs.
  always_ff @(posedge clk) begin
    if (ih) sr_q <= sr_d;
  end

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= lenw'(depth));
  assign fill_inc = fill_q + lenw'(1);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;

    if (cfg_load) begin
      if (state_q == EMPTY && !flush && !ih && cfg_ok) len_d = cfg_len;
      else cfg_err_d = 1'b1;
    end

    case (state_q)
      EMPTY: begin
        if (ih) begin
          fill_d  = lenw'(1);
          state_d = (len_q == lenw'(1)) ? RUN : FILL;
        end
      end
      FILL: begin
        if (ih) begin
          fill_d = fill_inc;
          if (fill_inc == len_q) state_d = RUN;
        end
        if (flush) state_d = FLUSH;
      end
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (oh) begin
          fill_d = fill_q - lenw'(1);
          if (fill_q == lenw'(1)) state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      fill_q    <= '0;
      len_q     <= lenw'(depth);
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign fill    = fill_q;
  assign busy    = (state_q != EMPTY);

endmodule

// File: tb/tb_sr_delay_sched.sv
// Self-checking bench for sr_delay_sched: directed test-plan steps followed by
// a random phase, all checked against a queue-based model of held samples.
module tb_sr_delay_sched;
  localparam int width = 8;
  localparam int depth = 130;
  localparam int lenw  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [lenw-1:0] cfg_len;
  logic            cfg_load;
  logic            cfg_err;
  logic            flush;
  logic [lenw-1:0] fill;
  logic            busy;

  sr_delay_sched_if #(.width(width)) bus ();

  sr_delay_sched #(.width(width), .depth(depth), .lenw(lenw)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_len  (cfg_len),
    .cfg_load (cfg_load),
    .cfg_err  (cfg_err),
    .flush    (flush),
    .fill     (fill),
    .busy     (busy),
    .s        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: queue of held samples (newest at front), active length, draining flag.
  logic [width-1:0] model_q [$];
  int               model_len;
  bit               model_flushing;
  bit               model_err;

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit iv, logic [width-1:0] d, bit ordy, bit fl, bit ld,
                       logic [lenw-1:0] len);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    cfg_load      = ld;
    cfg_len       = len;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_len      = depth;
    model_flushing = 1'b0;
    model_err      = 1'b0;
  endtask

  // Check the DUT mid-cycle against the model, then advance both by one clock.
  task automatic cycle();
    bit               exp_ir, exp_ov, ih, oh, empty_now, was_active, cfg_ok;
    logic [width-1:0] exp_od;
    @(negedge clk);
    empty_now = (model_q.size() == 0) && !model_flushing;
    if (rst) begin
      exp_ir = 1'b0; exp_ov = 1'b0;
    end else if (model_flushing) begin
      exp_ir = 1'b0; exp_ov = 1'b1;
    end else if (model_q.size() < model_len) begin
      exp_ir = 1'b1; exp_ov = 1'b0;
    end else begin
      exp_ir = bus.out_ready; exp_ov = bus.in_valid;
    end
    exp_od = exp_ov ? model_q[$] : '0;

    check_output("in_ready",  32'(bus.in_ready),  32'(exp_ir));
    check_output("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check_output("out_data",  32'(bus.out_data),  32'(exp_od));
    check_output("fill",      32'(fill),          32'(model_q.size()));
    check_output("busy",      32'(busy),          32'(!empty_now));
    check_output("cfg_err",   32'(cfg_err),       32'(model_err));

    ih = bus.in_valid && exp_ir;
    oh = exp_ov && bus.out_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      was_active = (model_q.size() > 0) && !model_flushing;
      cfg_ok     = (cfg_len >= 1) && (int'(cfg_len) <= depth);
      model_err  = 1'b0;
      if (cfg_load) begin
        if (empty_now && !flush && !ih && cfg_ok) model_len = int'(cfg_len);
        else model_err = 1'b1;
      end
      if (oh) void'(model_q.pop_back());
      if (ih) model_q.push_front(bus.in_data);
      if (flush && was_active) model_flushing = 1'b1;
      if (model_flushing && model_q.size() == 0) model_flushing = 1'b0;
    end
    #1;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
      cycle();
    end
  endtask

  task automatic push(logic [width-1:0] d);
    drive(1'b1, d, 1'b1, 1'b0, 1'b0, '0);
    cycle();
  endtask

  task automatic load(logic [lenw-1:0] len);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, len);
    cycle();
  endtask

  task automatic flush_and_drain(int n);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    cycle();
    idle_cycles(n);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'd3);
    cycle();
    rst = 1'b0;

    $display("[TB] step 1: L=4 push 1..6");
    load(8'd4);
    for (int i = 1; i <= 6; i++) push(8'(i));

    $display("[TB] step 2: downstream stall in RUN");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, '0);
      cycle();
    end
    for (int i = 7; i <= 10; i++) push(8'(i));
    flush_and_drain(6);

    $display("[TB] step 3: flush with coincident push");
    load(8'd4);
    push(8'd7); push(8'd8); push(8'd9);
    drive(1'b1, 8'd10, 1'b1, 1'b1, 1'b0, '0);
    cycle();
    idle_cycles(6);

    $display("[TB] step 4: configuration errors");
    load(8'd0);
    idle_cycles(1);
    load(8'd131);
    idle_cycles(1);
    push(8'h21);
    load(8'd2);
    idle_cycles(1);
    flush_and_drain(2);
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'd2);
    cycle();
    flush_and_drain(2);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 8'd2);
    cycle();
    load(8'd1);
    push(8'hA1); push(8'hA2); push(8'hA3);
    flush_and_drain(2);

    $display("[TB] step 5: L=130 stream of 260");
    load(8'd130);
    for (int i = 0; i < 260; i++) push(8'(i));

    $display("[TB] step 6: reset in RUN");
    flush_and_drain(131);
    load(8'd4);
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    rst = 1'b1;
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 132; i++) push(8'(8'h40 + i));
    flush_and_drain(131);

    $display("[TB] random phase");
    for (int i = 0; i < 1500; i++) begin
      logic [lenw-1:0] rlen;
      rlen = ($urandom % 2 == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 140));
      rst = ($urandom % 300 == 0);
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0,
            ($urandom % 40) == 0, ($urandom % 8) == 0, rlen);
      cycle();
    end
    rst = 1'b0;
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
